// File: rtl/connect4_pkg.sv
// Shared Connect-Four types: cell encoding, drop FSM states,
// default board size and flat cell index helper.
package connect4_pkg;

  localparam int FILAS_DEF    = 6;
  localparam int COLUMNAS_DEF = 7;

  typedef enum logic [1:0] {
    VACIA    = 2'b00,
    ROJA     = 2'b01,
    AMARILLA = 2'b10
  } celda_t;

  typedef enum logic [2:0] {
    IDLE,
    VALIDAR,
    CAER,
    ESCRIBIR,
    FIN
  } estado_colocador_t;

  function automatic int idx_celda(
    input int r,
    input int c,
    input int ncol = COLUMNAS_DEF
  );
    return r * ncol + c;
  endfunction

endpackage

// File: rtl/temporizador_caida.sv
// Dwell counter for the falling-piece animation: fin pulses
// every CICLOS clocks while clr is low.
module temporizador_caida #(
  parameter int CICLOS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic fin
);

  localparam int CW = (CICLOS > 1) ? $clog2(CICLOS) : 1;

  logic [CW-1:0] cnt;

  assign fin = (cnt == CW'(CICLOS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || fin) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/colocador_ficha.sv
// Connect-Four piece-drop stage: validates a column, lets the piece fall
// to the lowest free row and writes it. Animation: COLOCADOR_ANIMACION_EN.
module colocador_ficha
  import connect4_pkg::*;
#(
  parameter int FILAS    = FILAS_DEF,
  parameter int COLUMNAS = COLUMNAS_DEF
`ifdef COLOCADOR_ANIMACION_EN
  , parameter int CAIDA_CICLOS = 4
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reiniciar,
  input  logic       habilitado,
  input  logic       soltar,
  input  logic [2:0] col_sel,
  input  logic       is_red,
  output logic       ocupado,
  output logic       ficha_colocada,
  output logic       jugada_invalida,
  output logic [2:0] fila_colocada,
  output logic [2:0] col_colocada,
  output logic       tablero_lleno,
`ifdef COLOCADOR_ANIMACION_EN
  output logic       ficha_cayendo,
  output logic [2:0] fila_caida,
  output logic [2:0] col_caida,
`endif
  output logic [FILAS*COLUMNAS*2-1:0] tablero
);

  localparam logic [2:0] ULT_FILA = 3'(FILAS - 1);

  estado_colocador_t estado, estado_sig;

  celda_t     celdas [FILAS][COLUMNAS];
  logic [2:0] fila_q;
  logic [2:0] col_q;
  logic       rojo_q;
  logic       columna_llena;
  logic       toca_fondo;
  logic       paso;
  logic       inv_d;
  logic       inv_p1;
  logic       todas_llenas;

  assign columna_llena = (int'(col_q) >= COLUMNAS)
                      || (celdas[0][col_q] != VACIA);

  assign toca_fondo = (fila_q == ULT_FILA)
                   || (celdas[fila_q + 3'd1][col_q] != VACIA);

`ifdef COLOCADOR_ANIMACION_EN
  temporizador_caida #(
    .CICLOS(CAIDA_CICLOS)
  ) u_temporizador (
    .clk  (clk),
    .reset(reset),
    .clr  (estado != CAER),
    .fin  (paso)
  );

  assign ficha_cayendo = (estado == CAER);
  assign fila_caida    = fila_q;
  assign col_caida     = col_q;
`else
  assign paso = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado <= IDLE;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      IDLE:     if (soltar && habilitado) estado_sig = VALIDAR;
      VALIDAR:  estado_sig = columna_llena ? IDLE : CAER;
      CAER:     if (toca_fondo) estado_sig = ESCRIBIR;
      ESCRIBIR: estado_sig = FIN;
      FIN:      estado_sig = IDLE;
      default:  estado_sig = IDLE;
    endcase
    if (reiniciar) estado_sig = IDLE;
  end

  always_comb begin
    ocupado        = (estado != IDLE);
    ficha_colocada = (estado == FIN) && !reiniciar;
    inv_d          = (estado == VALIDAR) && columna_llena && !reiniciar;
  end

  always_comb begin
    todas_llenas = 1'b1;
    for (int c = 0; c < COLUMNAS; c++) begin
      if (celdas[0][c] == VACIA) todas_llenas = 1'b0;
    end
  end

  // invalid pulse is delayed one extra stage to land two cycles after soltar
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fila_q          <= '0;
      col_q           <= '0;
      rojo_q          <= 1'b0;
      fila_colocada   <= '0;
      col_colocada    <= '0;
      inv_p1          <= 1'b0;
      jugada_invalida <= 1'b0;
      tablero_lleno   <= 1'b0;
      for (int r = 0; r < FILAS; r++)
        for (int c = 0; c < COLUMNAS; c++)
          celdas[r][c] <= VACIA;
    end else if (reiniciar) begin
      fila_q          <= '0;
      fila_colocada   <= '0;
      col_colocada    <= '0;
      inv_p1          <= 1'b0;
      jugada_invalida <= 1'b0;
      tablero_lleno   <= 1'b0;
      for (int r = 0; r < FILAS; r++)
        for (int c = 0; c < COLUMNAS; c++)
          celdas[r][c] <= VACIA;
    end else begin
      inv_p1          <= inv_d;
      jugada_invalida <= inv_p1;
      tablero_lleno   <= todas_llenas;
      unique case (estado)
        IDLE: begin
          if (soltar && habilitado) begin
            col_q  <= col_sel;
            rojo_q <= is_red;
          end
        end
        VALIDAR: fila_q <= '0;
        CAER: begin
          if (!toca_fondo && paso) fila_q <= fila_q + 3'd1;
        end
        ESCRIBIR: begin
          celdas[fila_q][col_q] <= rojo_q ? ROJA : AMARILLA;
          fila_colocada         <= fila_q;
          col_colocada          <= col_q;
        end
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < FILAS; r++) begin : g_fila
    for (genvar c = 0; c < COLUMNAS; c++) begin : g_col
      localparam int I = idx_celda(r, c, COLUMNAS);
      assign tablero[2*I +: 2] = celdas[r][c];
    end
  end

endmodule

// File: tb/tb_colocador_ficha.sv
// Self-checking bench for colocador_ficha: random drops against a
// board-array model of gravity, latency and pulse rules.
module tb_colocador_ficha;

  localparam int F = 6;
  localparam int C = 7;
`ifdef COLOCADOR_ANIMACION_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reiniciar = 1'b0;
  logic       habilitado = 1'b1;
  logic       soltar = 1'b0;
  logic [2:0] col_sel = '0;
  logic       is_red = 1'b0;
  logic       ocupado;
  logic       ficha_colocada;
  logic       jugada_invalida;
  logic [2:0] fila_colocada;
  logic [2:0] col_colocada;
  logic       tablero_lleno;
`ifdef COLOCADOR_ANIMACION_EN
  logic       ficha_cayendo;
  logic [2:0] fila_caida;
  logic [2:0] col_caida;
`endif
  logic [F*C*2-1:0] tablero;

  int compared = 0;
  int mismatched = 0;
  int m [F][C];

  always #5 clk = ~clk;

  colocador_ficha dut (
    .clk            (clk),
    .reset          (reset),
    .reiniciar      (reiniciar),
    .habilitado     (habilitado),
    .soltar         (soltar),
    .col_sel        (col_sel),
    .is_red         (is_red),
    .ocupado        (ocupado),
    .ficha_colocada (ficha_colocada),
    .jugada_invalida(jugada_invalida),
    .fila_colocada  (fila_colocada),
    .col_colocada   (col_colocada),
    .tablero_lleno  (tablero_lleno),
`ifdef COLOCADOR_ANIMACION_EN
    .ficha_cayendo  (ficha_cayendo),
    .fila_caida     (fila_caida),
    .col_caida      (col_caida),
`endif
    .tablero        (tablero)
  );

  function automatic logic [F*C*2-1:0] modelo();
    logic [F*C*2-1:0] v;
    v = '0;
    for (int r = 0; r < F; r++)
      for (int c = 0; c < C; c++)
        v[2*(r*C+c) +: 2] = 2'(m[r][c]);
    return v;
  endfunction

  function automatic bit modelo_lleno();
    for (int c = 0; c < C; c++)
      if (m[0][c] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int fila_libre(input int c);
    for (int r = F - 1; r >= 0; r--)
      if (m[r][c] == 0) return r;
    return -1;
  endfunction

  task automatic limpiar_modelo();
    for (int r = 0; r < F; r++)
      for (int c = 0; c < C; c++)
        m[r][c] = 0;
  endtask

  task automatic do_drop(input int c, input bit red,
                         input bit hold, input bit cae_hab);
    int row, lat, got, npulse;
    bit inv, got_f;
    row = (c < C) ? fila_libre(c) : -1;
    inv = (row < 0);
    lat = inv ? 2 : 3 + row * D;
    @(negedge clk);
    col_sel = 3'(c);
    is_red  = red;
    soltar  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) soltar = 1'b0;
    if (cae_hab) habilitado = 1'b0;
    compared++;
    if (ocupado !== 1'b1) begin
      mismatched++;
      $display("FAIL ocupado_start: got %b want 1", ocupado);
    end
    npulse = 0;
    got = -1;
    got_f = 1'b0;
    for (int n = 1; n <= lat + 6; n++) begin
      @(posedge clk);
      #1;
`ifdef COLOCADOR_ANIMACION_EN
      if (!inv && n <= 1 + row * D) begin
        compared++;
        if (ficha_cayendo !== 1'b1 || fila_caida !== 3'((n - 1) / D)) begin
          mismatched++;
          $display("FAIL anim n=%0d: cay=%b fila=%0d want 1/%0d",
                   n, ficha_cayendo, fila_caida, (n - 1) / D);
        end
      end
`endif
      if (ficha_colocada === 1'b1 || jugada_invalida === 1'b1) begin
        npulse++;
        if (got < 0) begin
          got = n;
          got_f = ficha_colocada;
        end
        soltar = 1'b0;
      end
    end
    habilitado = 1'b1;
    compared++;
    if (npulse != 1 || got != lat) begin
      mismatched++;
      $display("FAIL latency col=%0d: pulses=%0d at %0d want 1 at %0d",
               c, npulse, got, lat);
    end
    compared++;
    if (got_f !== !inv) begin
      mismatched++;
      $display("FAIL pulse_kind col=%0d: ficha=%b want %b", c, got_f, !inv);
    end
    if (!inv) begin
      m[row][c] = red ? 1 : 2;
      compared++;
      if (fila_colocada !== 3'(row) || col_colocada !== 3'(c)) begin
        mismatched++;
        $display("FAIL pos: got %0d,%0d want %0d,%0d",
                 fila_colocada, col_colocada, row, c);
      end
    end
    compared++;
    if (tablero !== modelo()) begin
      mismatched++;
      $display("FAIL tablero col=%0d: got %h want %h", c, tablero, modelo());
    end
    compared++;
    if (tablero_lleno !== modelo_lleno() || ocupado !== 1'b0) begin
      mismatched++;
      $display("FAIL lleno/ocupado: got %b/%b want %b/0",
               tablero_lleno, ocupado, modelo_lleno());
    end
  endtask

  task automatic pulso_reiniciar();
    @(negedge clk);
    reiniciar = 1'b1;
    @(negedge clk);
    reiniciar = 1'b0;
    limpiar_modelo();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (tablero !== '0 || ocupado !== 1'b0 || ficha_colocada !== 1'b0 ||
        jugada_invalida !== 1'b0 || fila_colocada !== 3'd0 ||
        col_colocada !== 3'd0 || tablero_lleno !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: tab=%h oc=%b fc=%b ji=%b f=%0d c=%0d ll=%b",
               tablero, ocupado, ficha_colocada, jugada_invalida,
               fila_colocada, col_colocada, tablero_lleno);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_first_drop();
    do_drop(3, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reiniciar();
    @(negedge clk);
    col_sel = 3'd4;
    is_red  = 1'b0;
    soltar  = 1'b1;
    @(negedge clk);
    soltar = 1'b0;
    repeat (3) @(negedge clk);
    reiniciar = 1'b1;
    @(posedge clk);
    #1;
    reiniciar = 1'b0;
    limpiar_modelo();
    compared++;
    if (tablero !== '0 || ocupado !== 1'b0 || fila_colocada !== 3'd0 ||
        col_colocada !== 3'd0 || tablero_lleno !== 1'b0) begin
      mismatched++;
      $display("FAIL reiniciar: tab=%h oc=%b f=%0d c=%0d",
               tablero, ocupado, fila_colocada, col_colocada);
    end
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      compared++;
      if (ficha_colocada !== 1'b0 || jugada_invalida !== 1'b0) begin
        mismatched++;
        $display("FAIL reiniciar_pulse: fc=%b ji=%b want 0/0",
                 ficha_colocada, jugada_invalida);
      end
    end
  endtask

  task automatic test_column_fill();
    for (int i = 0; i < F + 1; i++)
      do_drop(0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic test_out_of_range();
    do_drop(7, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_drop(2, 1'b0, 1'b1, 1'b0);
    do_drop(2, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_habilitado();
    @(negedge clk);
    habilitado = 1'b0;
    col_sel = 3'd5;
    soltar = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      compared++;
      if (ocupado !== 1'b0 || ficha_colocada !== 1'b0 ||
          jugada_invalida !== 1'b0) begin
        mismatched++;
        $display("FAIL hab_off: oc=%b fc=%b ji=%b want 0",
                 ocupado, ficha_colocada, jugada_invalida);
      end
    end
    @(negedge clk);
    soltar = 1'b0;
    habilitado = 1'b1;
    do_drop(5, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      do_drop($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  task automatic test_fill_board();
    int c;
    pulso_reiniciar();
    for (int i = 0; i < F * C; i++) begin
      c = $urandom_range(0, C - 1);
      while (m[0][c] != 0) c = (c + 1) % C;
      do_drop(c, 1'(i % 2 == 0), 1'b0, 1'b0);
    end
    compared++;
    if (tablero_lleno !== 1'b1) begin
      mismatched++;
      $display("FAIL lleno_final: got %b want 1", tablero_lleno);
    end
    do_drop($urandom_range(0, C - 1), 1'b1, 1'b0, 1'b0);
    do_drop($urandom_range(0, C - 1), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    limpiar_modelo();
    test_reset();
    test_first_drop();
    test_reiniciar();
    test_column_fill();
    test_out_of_range();
    test_back_to_back();
    test_habilitado();
    test_random();
    test_fill_board();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
